// File: rtl/debounce_scheduler.sv
// Time-multiplexed debouncer: one tick, one shared compare/count slot visiting each button in turn.
// Optional long-press detection is compiled in with `define DEBOUNCE_HOLD_EN (adds the hold port).
module debounce_scheduler #(
   parameter int N_BUTTONS    = 4,
   parameter int TICK_MAX     = 50000,
   parameter int STABLE_COUNT = 4,
   parameter int HOLD_TICKS   = 500
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_BUTTONS-1:0] button,
   input  logic                 enable,
   output logic [N_BUTTONS-1:0] level,
   output logic [N_BUTTONS-1:0] press,
   output logic [N_BUTTONS-1:0] release_p,
   output logic                 busy
`ifdef DEBOUNCE_HOLD_EN
   ,
   output logic [N_BUTTONS-1:0] hold
`endif
);

   localparam int TW = $clog2(TICK_MAX);
   localparam int IW = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1;
   localparam int CW = 4;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_BUTTONS - 1);

   generate
      if (TICK_MAX < N_BUTTONS + 2) begin : g_tick_check
         $error("debounce_scheduler: TICK_MAX must be >= N_BUTTONS+2");
      end
      if (STABLE_COUNT < 2 || STABLE_COUNT > 15) begin : g_stable_check
         $error("debounce_scheduler: STABLE_COUNT must be in 2..15");
      end
      if (N_BUTTONS < 1 || N_BUTTONS > 16) begin : g_n_check
         $error("debounce_scheduler: N_BUTTONS must be in 1..16");
      end
      if (HOLD_TICKS < 1) begin : g_hold_check
         $error("debounce_scheduler: HOLD_TICKS must be >= 1");
      end
   endgenerate

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                 state;
   logic [IW-1:0]          idx;
   logic [TW-1:0]          tcnt;
   logic                   tick;
   logic [N_BUTTONS-1:0]   sync1;
   logic [N_BUTTONS-1:0]   sync2;
   logic [CW-1:0]          cnt [N_BUTTONS];

   logic                   cur_sync;
   logic                   cur_level;
   logic [CW-1:0]          cur_cnt;
   logic                   differ;
   logic                   at_limit;

   // Two-stage synchronizer for the asynchronous raw inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= button;
         sync2 <= sync1;
      end
   end

   assign tick = (tcnt == TW'(TICK_MAX - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt <= '0;
      end else if (!enable || tick) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + 1'b1;
      end
   end

   // Shared slot: select the visited button's state.
   assign cur_sync  = sync2[idx];
   assign cur_level = level[idx];
   assign cur_cnt   = cnt[idx];
   assign differ    = (cur_sync != cur_level);
   assign at_limit  = (cur_cnt == CW'(STABLE_COUNT - 1));

`ifdef DEBOUNCE_HOLD_EN
   localparam int HW = $clog2(HOLD_TICKS + 1);
   logic [HW-1:0] hcnt [N_BUTTONS];
   logic [HW-1:0] cur_hcnt;
   assign cur_hcnt = hcnt[idx];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         busy      <= 1'b0;
         level     <= '0;
         press     <= '0;
         release_p <= '0;
         for (int i = 0; i < N_BUTTONS; i++) cnt[i] <= '0;
`ifdef DEBOUNCE_HOLD_EN
         hold <= '0;
         for (int i = 0; i < N_BUTTONS; i++) hcnt[i] <= '0;
`endif
      end else begin
         press     <= '0;
         release_p <= '0;
`ifdef DEBOUNCE_HOLD_EN
         hold <= '0;
`endif
         case (state)
            IDLE: begin
               if (tick) begin
                  state <= SCAN;
                  idx   <= '0;
                  busy  <= 1'b1;
               end
            end
            SCAN: begin
               if (!differ) begin
                  cnt[idx] <= '0;
               end else if (at_limit) begin
                  cnt[idx]   <= '0;
                  level[idx] <= ~cur_level;
                  if (cur_level) release_p[idx] <= 1'b1;
                  else           press[idx]     <= 1'b1;
               end else begin
                  cnt[idx] <= cur_cnt + 1'b1;
               end
`ifdef DEBOUNCE_HOLD_EN
               // Saturating at HOLD_TICKS guarantees one hold pulse per press.
               if (!cur_level || (differ && at_limit)) begin
                  hcnt[idx] <= '0;
               end else if (cur_hcnt != HW'(HOLD_TICKS)) begin
                  hcnt[idx] <= cur_hcnt + 1'b1;
                  if (cur_hcnt == HW'(HOLD_TICKS - 1)) hold[idx] <= 1'b1;
               end
`endif
               if (idx == LAST_IDX) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  idx   <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               idx   <= '0;
            end
         endcase
      end
   end

endmodule
